// File: rtl/eth_pkt_tx_buf.sv
// Store-and-forward TX packet buffer feeding the MAC pkt_tx_* interface.
// Define ETH_TX_BUF_STATS_EN to build the tx/drop packet counters; otherwise both stats read 0.

module eth_pkt_tx_buf #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk156m25,
    input  logic        reset_156m25_n,
    input  logic [63:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [2:0]  in_mod,
    input  logic        in_val,
    output logic        in_rdy,
    output logic [63:0] pkt_tx_data,
    output logic        pkt_tx_sop,
    output logic        pkt_tx_eop,
    output logic [2:0]  pkt_tx_mod,
    output logic        pkt_tx_val,
    input  logic        pkt_tx_full,
    output logic [31:0] stat_tx_pkts,
    output logic [31:0] stat_drop_pkts
);
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {WIDLE, WPKT, WDROP} wst_t;
    typedef enum logic       {RIDLE, RSEND}       rdst_t;

    wst_t              r_wrst, w_wrst_nxt;
    rdst_t             r_rdst, w_rdst_nxt;
    logic [ADDR_W:0]   r_wr_ptr, r_wr_cmt, r_rd_ptr;
    logic [ADDR_W:0]   w_wr_ptr_nxt, w_wr_cmt_nxt, w_used;
    logic [ADDR_W-1:0] w_waddr;
    logic [67:0]       r_mem [DEPTH];
    logic [67:0]       w_rd_word;
    logic              r_full_q;
    logic              w_full, w_oversize, w_rdy, w_acc, w_we, w_drop;
    logic              w_avail, w_issue;
    logic [63:0]       r_tx_data;
    logic              r_tx_sop, r_tx_eop, r_tx_val;
    logic [2:0]        r_tx_mod;

    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_used == L_DEPTH);
    // A packet that alone fills the buffer can never commit, so it is thrown away.
    assign w_oversize = (r_wrst == WPKT) && w_full && (r_wr_cmt == r_rd_ptr);

    always_comb begin
        case (r_wrst)
            WIDLE:   w_rdy = !w_full;
            WPKT:    w_rdy = !w_full || w_oversize;
            default: w_rdy = 1'b1;
        endcase
    end

    assign in_rdy = reset_156m25_n & w_rdy;
    assign w_acc  = in_val & in_rdy;

    always_comb begin
        w_wrst_nxt   = r_wrst;
        w_wr_ptr_nxt = r_wr_ptr;
        w_wr_cmt_nxt = r_wr_cmt;
        w_waddr      = r_wr_ptr[ADDR_W-1:0];
        w_we         = 1'b0;
        w_drop       = 1'b0;
        case (r_wrst)
            WIDLE: begin
                if (w_acc && in_sop) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (in_eop) w_wr_cmt_nxt = r_wr_ptr + 1'b1;
                    else        w_wrst_nxt   = WPKT;
                end else if (w_acc) begin
                    w_drop = 1'b1;
                end
            end
            WPKT: begin
                if (w_oversize) begin
                    w_wr_ptr_nxt = r_wr_cmt;
                    w_drop       = 1'b1;
                    w_wrst_nxt   = (w_acc && in_eop) ? WIDLE : WDROP;
                end else if (w_acc && in_sop) begin
                    // Restart: the new SOP word overwrites the aborted packet's first slot.
                    w_drop       = 1'b1;
                    w_we         = 1'b1;
                    w_waddr      = r_wr_cmt[ADDR_W-1:0];
                    w_wr_ptr_nxt = r_wr_cmt + 1'b1;
                    if (in_eop) begin
                        w_wr_cmt_nxt = r_wr_cmt + 1'b1;
                        w_wrst_nxt   = WIDLE;
                    end
                end else if (w_acc) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (in_eop) begin
                        w_wr_cmt_nxt = r_wr_ptr + 1'b1;
                        w_wrst_nxt   = WIDLE;
                    end
                end
            end
            default: begin
                if (w_acc && in_eop) w_wrst_nxt = WIDLE;
            end
        endcase
    end

    always_ff @(posedge clk156m25) begin
        if (w_we) r_mem[w_waddr] <= {in_eop, (in_eop ? in_mod : 3'd0), in_data};
    end

    assign w_avail   = (r_rd_ptr != r_wr_cmt);
    assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];

    always_comb begin
        w_issue    = 1'b0;
        w_rdst_nxt = r_rdst;
        if (!r_full_q && (r_rdst == RSEND || w_avail)) begin
            w_issue    = 1'b1;
            w_rdst_nxt = w_rd_word[67] ? RIDLE : RSEND;
        end
    end

    always_ff @(posedge clk156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_wrst    <= WIDLE;
            r_rdst    <= RIDLE;
            r_wr_ptr  <= '0;
            r_wr_cmt  <= '0;
            r_rd_ptr  <= '0;
            r_full_q  <= 1'b0;
            r_tx_data <= '0;
            r_tx_sop  <= 1'b0;
            r_tx_eop  <= 1'b0;
            r_tx_mod  <= 3'd0;
            r_tx_val  <= 1'b0;
        end else begin
            r_wrst   <= w_wrst_nxt;
            r_rdst   <= w_rdst_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_wr_cmt <= w_wr_cmt_nxt;
            r_full_q <= pkt_tx_full;
            r_tx_val <= w_issue;
            r_tx_sop <= w_issue && (r_rdst == RIDLE);
            r_tx_eop <= w_issue && w_rd_word[67];
            r_tx_mod <= w_issue ? w_rd_word[66:64] : 3'd0;
            if (w_issue) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= w_rd_word[63:0];
            end
        end
    end

    assign pkt_tx_data = r_tx_data;
    assign pkt_tx_sop  = r_tx_sop;
    assign pkt_tx_eop  = r_tx_eop;
    assign pkt_tx_mod  = r_tx_mod;
    assign pkt_tx_val  = r_tx_val;

`ifdef ETH_TX_BUF_STATS_EN
    logic [31:0] r_stat_tx, r_stat_drop;

    always_ff @(posedge clk156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_stat_tx   <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_issue && w_rd_word[67]) r_stat_tx <= r_stat_tx + 1'b1;
            if (w_drop) r_stat_drop <= r_stat_drop + 1'b1;
        end
    end

    assign stat_tx_pkts   = r_stat_tx;
    assign stat_drop_pkts = r_stat_drop;
`else
    logic w_stats_unused;
    assign w_stats_unused = w_drop;
    assign stat_tx_pkts   = '0;
    assign stat_drop_pkts = '0;
`endif

endmodule

// File: tb/tb_eth_pkt_tx_buf.sv
// Bench for eth_pkt_tx_buf (DEPTH=16): vector table, directed corner sequences and a random
// run checked against a packet-level model of the accept/drop rules.

module tb_eth_pkt_tx_buf;
    localparam int DEPTH = 16;

    logic        clk156m25 = 1'b0;
    logic        reset_156m25_n;
    logic [63:0] in_data;
    logic        in_sop, in_eop, in_val, in_rdy;
    logic [2:0]  in_mod;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_sop, pkt_tx_eop, pkt_tx_val, pkt_tx_full;
    logic [2:0]  pkt_tx_mod;
    logic [31:0] stat_tx_pkts, stat_drop_pkts;

    eth_pkt_tx_buf #(.DEPTH(DEPTH)) dut (
        .clk156m25(clk156m25), .reset_156m25_n(reset_156m25_n),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod),
        .in_val(in_val), .in_rdy(in_rdy),
        .pkt_tx_data(pkt_tx_data), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
        .pkt_tx_mod(pkt_tx_mod), .pkt_tx_val(pkt_tx_val), .pkt_tx_full(pkt_tx_full),
        .stat_tx_pkts(stat_tx_pkts), .stat_drop_pkts(stat_drop_pkts)
    );

    always #5 clk156m25 = ~clk156m25;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
    } wrd_t;

    typedef struct packed {
        logic v, s, e; logic [2:0] m; logic [63:0] d;
        logic ov, os, oe; logic [2:0] om; logic [63:0] od;
    } vec_t;

    int   nchecks = 0;
    int   nfail   = 0;
    wrd_t got[$];
    wrd_t exp_q[$];
    wrd_t cur[$];
    int   ms;
    int   m_tx, m_drop;
    bit   fh1, fh2;
    bit   rnd_bp;
    int   bp_cnt;
    vec_t tbl[12];

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        nchecks++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Packet-level reference: which words survive and what the MAC must see.
    function automatic void emit();
        cur[0].sop = 1'b1;
        foreach (cur[i]) exp_q.push_back(cur[i]);
        cur.delete();
        m_tx++;
        ms = 0;
    endfunction

    function automatic void model_word(input bit s, input bit e, input logic [2:0] m, input logic [63:0] d);
        wrd_t w;
        w.sop = 1'b0; w.eop = e; w.mod = e ? m : 3'd0; w.data = d;
        case (ms)
            0: if (!s) m_drop++;
               else begin cur.delete(); cur.push_back(w); if (e) emit(); else ms = 1; end
            1: if (s) begin
                   m_drop++; cur.delete(); cur.push_back(w);
                   if (e) emit();
               end else begin
                   cur.push_back(w);
                   if (e) emit();
                   else if (cur.size() == DEPTH) begin m_drop++; cur.delete(); ms = 2; end
               end
            default: if (e) ms = 0;
        endcase
    endfunction

    function automatic void model_reset();
        cur.delete(); exp_q.delete(); got.delete();
        ms = 0; m_tx = 0; m_drop = 0; fh1 = 0; fh2 = 0;
    endfunction

    task automatic mon();
        wrd_t w;
        if (reset_156m25_n !== 1'b1) return;
        if (fh1 && fh2) chk(pkt_tx_val == 1'b0, "bp_hold", pkt_tx_val, 0);
        fh2 = fh1;
        fh1 = pkt_tx_full;
        if (pkt_tx_val) begin
            w = {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data};
            got.push_back(w);
        end else begin
            chk({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} == 5'd0, "idle_ctl", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
        end
    endtask

    task automatic half_neg();
        @(negedge clk156m25);
        mon();
    endtask

    task automatic half_pos();
        @(posedge clk156m25);
        #1;
        if (rnd_bp) begin
            if (bp_cnt <= 0) begin
                pkt_tx_full = !pkt_tx_full;
                bp_cnt = pkt_tx_full ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 8));
            end else bp_cnt--;
        end
    endtask

    task automatic step();
        half_neg();
        half_pos();
    endtask

    task automatic put(input bit s, input bit e, input logic [2:0] m, input logic [63:0] d);
        in_val = 1'b1; in_sop = s; in_eop = e; in_mod = m; in_data = d;
        for (int t = 0; t < 2000; t++) begin
            half_neg();
            if (in_rdy) begin
                model_word(s, e, m, d);
                half_pos();
                in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
                return;
            end
            half_pos();
        end
        chk(1'b0, "put_timeout", 0, 1);
        in_val = 1'b0;
    endtask

    task automatic chk_stats(input string name);
`ifdef ETH_TX_BUF_STATS_EN
        chk(stat_tx_pkts == 32'(m_tx), {name, "_stat_tx"}, stat_tx_pkts, m_tx);
        chk(stat_drop_pkts == 32'(m_drop), {name, "_stat_drop"}, stat_drop_pkts, m_drop);
`else
        chk(stat_tx_pkts == 32'd0, {name, "_stat_tx"}, stat_tx_pkts, 0);
        chk(stat_drop_pkts == 32'd0, {name, "_stat_drop"}, stat_drop_pkts, 0);
`endif
    endtask

    task automatic drain(input string name);
        int t;
        rnd_bp = 1'b0;
        pkt_tx_full = 1'b0;
        t = 0;
        while (got.size() < exp_q.size() && t < 3000) begin step(); t++; end
        chk(got.size() >= exp_q.size(), {name, "_drain"}, got.size(), exp_q.size());
        repeat (6) step();
        chk(got.size() == exp_q.size(), {name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk(got[i] == exp_q[i], $sformatf("%s_word%0d", name, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
        chk_stats(name);
    endtask

    function automatic vec_t mk(input logic v, s, e, input logic [2:0] m, input logic [63:0] d,
                                input logic ov, os, oe, input logic [2:0] om, input logic [63:0] od);
        vec_t r;
        r = {v, s, e, m, d, ov, os, oe, om, od};
        return r;
    endfunction

    initial begin
        int nv;
        int drop0;
        logic [63:0] D0, D1, D2, A, B;
        D0 = 64'h0123_4567_89AB_CDEF; D1 = 64'hDEAD_BEEF_0000_0001; D2 = 64'hCAFE_F00D_5555_AAAA;
        A  = 64'hA5A5_0000_1111_2222; B  = 64'h5A5A_3333_4444_FFFF;
        // 3-word packet, then two single-word packets; outputs per cycle.
        tbl[0]  = mk(1,1,0,3'd0,D0, 0,0,0,3'd0,64'd0);
        tbl[1]  = mk(1,0,0,3'd0,D1, 0,0,0,3'd0,64'd0);
        tbl[2]  = mk(1,0,1,3'd5,D2, 0,0,0,3'd0,64'd0);
        tbl[3]  = mk(0,0,0,3'd0,64'd0, 0,0,0,3'd0,64'd0);
        tbl[4]  = mk(0,0,0,3'd0,64'd0, 1,1,0,3'd0,D0);
        tbl[5]  = mk(0,0,0,3'd0,64'd0, 1,0,0,3'd0,D1);
        tbl[6]  = mk(1,1,1,3'd0,A,     1,0,1,3'd5,D2);
        tbl[7]  = mk(1,1,1,3'd0,B,     0,0,0,3'd0,D2);
        tbl[8]  = mk(0,0,0,3'd0,64'd0, 1,1,1,3'd0,A);
        tbl[9]  = mk(0,0,0,3'd0,64'd0, 1,1,1,3'd0,B);
        tbl[10] = mk(0,0,0,3'd0,64'd0, 0,0,0,3'd0,B);
        tbl[11] = mk(0,0,0,3'd0,64'd0, 0,0,0,3'd0,B);

        reset_156m25_n = 1'b0;
        in_data = '0; in_sop = 0; in_eop = 0; in_mod = '0; in_val = 0;
        pkt_tx_full = 0; rnd_bp = 0; bp_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk156m25);
        #1;
        chk({in_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} == 7'd0, "rst_ctl",
            {in_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
        chk(pkt_tx_data == 64'd0, "rst_data", pkt_tx_data, 0);
        chk_stats("rst");
        reset_156m25_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            in_val = tbl[i].v; in_sop = tbl[i].s; in_eop = tbl[i].e; in_mod = tbl[i].m; in_data = tbl[i].d;
            if (tbl[i].v) model_word(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].d);
            half_neg();
            chk({in_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data} ==
                {1'b1, tbl[i].ov, tbl[i].os, tbl[i].oe, tbl[i].om, tbl[i].od}, $sformatf("vec%0d", i),
                {in_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data},
                {1'b1, tbl[i].ov, tbl[i].os, tbl[i].oe, tbl[i].om, tbl[i].od});
            half_pos();
        end
        in_val = 0; in_sop = 0; in_eop = 0;
        drain("vec");

        // 8-word packet, MAC full for 4 cycles mid-packet.
        for (int i = 0; i < 8; i++) put(i == 0, i == 7, (i == 7) ? 3'd2 : 3'd0, 64'hB0B0_0000_0000_0000 + 64'(i));
        step(); step();
        pkt_tx_full = 1'b1;
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            half_neg();
            if (k > 0 && pkt_tx_val) nv++;
            half_pos();
        end
        pkt_tx_full = 1'b0;
        chk(nv <= 1, "bp_after_rise", nv, 1);
        drain("bp8");

        // Oversize 20-word packet dropped, following 2-word packet intact.
        drop0 = m_drop;
        for (int i = 0; i < 20; i++) put(i == 0, i == 19, 3'd1, 64'hC000_0000_0000_0000 + 64'(i));
        put(1, 0, 3'd0, 64'h1111_2222_3333_4444);
        put(0, 1, 3'd7, 64'h5555_6666_7777_8888);
        chk(m_drop - drop0 == 1, "oversize_model_drop", m_drop - drop0, 1);
        drain("oversize");

        // Boundary: exactly DEPTH words fits, DEPTH+1 does not.
        for (int i = 0; i < DEPTH; i++) put(i == 0, i == DEPTH-1, 3'd3, 64'hD000_0000_0000_0000 + 64'(i));
        drain("depth16");
        for (int i = 0; i <= DEPTH; i++) put(i == 0, i == DEPTH, 3'd3, 64'hE000_0000_0000_0000 + 64'(i));
        put(1, 1, 3'd4, 64'h0BAD_F00D_0000_0001);
        drain("depth17");

        // Stray word, packet aborted by a new SOP, which then completes.
        drop0 = m_drop;
        put(0, 0, 3'd0, 64'h5757_5757_5757_5757);
        put(1, 0, 3'd0, 64'hAB00_0000_0000_0000);
        put(1, 0, 3'd0, 64'hAB00_0000_0000_0001);
        put(0, 1, 3'd6, 64'hAB00_0000_0000_0002);
        chk(m_drop - drop0 == 2, "abort_model_drop", m_drop - drop0, 2);
        chk(exp_q.size() == 2, "abort_model_words", exp_q.size(), 2);
        drain("abort");

        // Reset with one committed packet held back by the MAC and a partial one in flight.
        pkt_tx_full = 1'b1;
        step(); step();
        put(1, 0, 3'd0, 64'h7777_0000_0000_0001);
        put(0, 1, 3'd2, 64'h7777_0000_0000_0002);
        put(1, 0, 3'd0, 64'h7777_0000_0000_0003);
        reset_156m25_n = 1'b0;
        #1;
        chk({in_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} == 7'd0, "midrst_ctl",
            {in_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
        chk(pkt_tx_data == 64'd0, "midrst_data", pkt_tx_data, 0);
        chk({stat_tx_pkts, stat_drop_pkts} == 64'd0, "midrst_stats", {stat_tx_pkts, stat_drop_pkts}, 0);
        model_reset();
        pkt_tx_full = 1'b0;
        repeat (2) @(posedge clk156m25);
        #1;
        reset_156m25_n = 1'b1;
        half_neg();
        chk(in_rdy == 1'b1, "postrst_rdy", in_rdy, 1);
        half_pos();
        repeat (10) step();
        chk(got.size() == 0, "postrst_nosend", got.size(), 0);
        put(1, 1, 3'd1, 64'h9999_8888_7777_6666);
        drain("postrst");

        // Random traffic with random MAC backpressure.
        rnd_bp = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int r, len;
            bit noeop;
            r = int'($urandom_range(0, 99));
            repeat ($urandom_range(0, 2)) step();
            if (r < 6) begin
                put(0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), {$urandom, $urandom});
            end else begin
                len   = (r < 14) ? int'($urandom_range(17, 22)) : int'($urandom_range(1, 10));
                noeop = ($urandom_range(0, 9) == 0);
                for (int i = 0; i < len; i++)
                    put(i == 0, (i == len-1) && !noeop, 3'($urandom_range(0, 7)), {$urandom, $urandom});
            end
        end
        put(1, 0, 3'd0, 64'hF1F1_F1F1_0000_0000);
        put(0, 1, 3'd3, 64'hF1F1_F1F1_0000_0001);
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
